// File: rtl/rom_arb_pkg.sv
// Shared types and widths for the instruction-ROM port arbiter.
package rom_arb_pkg;

  localparam int unsigned ROM_ADDR_W = 10;
  localparam int unsigned ROM_DATA_W = 32;
  localparam int unsigned CONFLICT_W = 16;
  // Wide enough for MAX_WAIT values up to 15
  localparam int unsigned STARVE_W   = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

endpackage

// File: rtl/rom_arb_starve_ctr.sv
// Saturating count of consecutive I-port denials; force_i requests a forced I grant.
module rom_arb_starve_ctr
  import rom_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic force_i
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] cnt;

  // Any cycle without a pending, denied fetch restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (i_req && !i_gnt) begin
      if (cnt != CNT_MAX) cnt <= cnt + STARVE_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign force_i = (cnt == CNT_MAX);

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-port (fetch / constant-load) arbiter in front of the single-port instruction ROM.
// Optional conflict statistics counter enabled by defining ROM_ARB_STATS_EN.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ROM_ADDR_W,
  parameter int unsigned DATA_W   = ROM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W+1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_stall,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic [ADDR_W+1:0]     d_addr,
  output logic                  d_gnt,
  output logic                  d_stall,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic [ADDR_W-1:0]     rom_addr,
  output logic                  rom_sel,
  input  logic [DATA_W-1:0]     rom_data,
  output logic [CONFLICT_W-1:0] stat_conflicts
);

  gnt_e gnt;
  logic force_i;
  logic d_misaligned;
  logic i_req_live;
  logic d_req_live;
  logic unused_addr_bits;

  // Fetch is word-granular; the byte offset carries no information
  assign unused_addr_bits = ^i_addr[1:0];

  assign d_misaligned = (d_addr[1:0] != 2'b00);

  // Requests are ignored while reset is held so every output reads 0
  assign i_req_live = i_req & ~rst;
  assign d_req_live = d_req & ~rst;

  rom_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_gnt   (i_gnt),
    .force_i (force_i)
  );

  // D-port normally wins a conflict; a starved fetch takes one cycle
  always_comb begin
    gnt = GNT_NONE;
    if (i_req_live && d_req_live) begin
      gnt = force_i ? GNT_I : GNT_D;
    end else if (i_req_live) begin
      gnt = GNT_I;
    end else if (d_req_live) begin
      gnt = GNT_D;
    end
  end

  // ROM address/select follow the winner; a misaligned load keeps the ROM idle
  always_comb begin
    rom_addr = '0;
    rom_sel  = 1'b0;
    unique case (gnt)
      GNT_I: begin
        rom_addr = i_addr[ADDR_W+1:2];
        rom_sel  = 1'b1;
      end
      GNT_D: begin
        rom_addr = d_addr[ADDR_W+1:2];
        rom_sel  = ~d_misaligned;
      end
      default: begin
        rom_addr = '0;
        rom_sel  = 1'b0;
      end
    endcase
  end

  assign i_gnt   = (gnt == GNT_I);
  assign d_gnt   = (gnt == GNT_D);
  assign i_stall = i_req_live & ~i_gnt;
  assign d_stall = d_req_live & ~d_gnt;

  // One-cycle response path; rdata holds between grants
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt & d_misaligned;
      if (i_gnt) i_rdata <= rom_data;
      if (d_gnt) d_rdata <= d_misaligned ? '0 : rom_data;
    end
  end

`ifdef ROM_ARB_STATS_EN
  logic [CONFLICT_W-1:0] conflicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflicts <= '0;
    end else if (i_req && d_req && (conflicts != {CONFLICT_W{1'b1}})) begin
      conflicts <= conflicts + CONFLICT_W'(1);
    end
  end

  assign stat_conflicts = conflicts;
`else
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed vector table plus randomized traffic against a behavioural arbiter model.
module tb_rom_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req;
  logic [AW+1:0] i_addr, d_addr;
  logic          i_gnt, i_stall, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_gnt, d_stall, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] rom_addr;
  logic          rom_sel;
  logic [DW-1:0] rom_data;
  logic [15:0]   stat_conflicts;

  logic [DW-1:0] rom_mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_sel ? rom_mem[rom_addr] : '0;

  rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_stall(i_stall),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_stall(d_stall),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
    .stat_conflicts(stat_conflicts)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ir;
    logic [11:0] ia;
    logic        dr;
    logic [11:0] da;
    logic        eig;
    logic        edg;
    logic        esel;
    logic [9:0]  eaddr;
    logic        eirv;
    logic [31:0] eird;
    logic        edrv;
    logic [31:0] edrd;
    logic        ederr;
  } vec_t;

  vec_t tbl [14];

  // Behavioural model state
  int          denials;
  int          stat_m;
  logic        m_irv, m_drv, m_derr;
  logic [31:0] m_ird, m_drd;
  int          stats_en;

  initial begin
`ifdef ROM_ARB_STATS_EN
    stats_en = 1;
`else
    stats_en = 0;
`endif
    for (int k = 0; k < (1 << AW); k++) rom_mem[k] = $urandom;
    rom_mem[1] = 32'h12345678;
    rom_mem[2] = 32'hDEADBEEF;
    rom_mem[4] = 32'hCAFEF00D;
    rom_mem[8] = 32'h0BADC0DE;

    //         ir  ia      dr  da      ig dg sel addr  irv ird           drv drd           err
    tbl[0]  = '{1, 12'h008, 0, 12'h000, 1, 0, 1, 10'd2, 0, 32'h0,        0, 32'h0,        0};
    tbl[1]  = '{1, 12'h004, 1, 12'h010, 0, 1, 1, 10'd4, 1, 32'hDEADBEEF, 0, 32'h0,        0};
    tbl[2]  = '{1, 12'h004, 0, 12'h000, 1, 0, 1, 10'd1, 0, 32'h0,        1, 32'hCAFEF00D, 0};
    tbl[3]  = '{0, 12'h000, 0, 12'h000, 0, 0, 0, 10'd0, 1, 32'h12345678, 0, 32'h0,        0};
    tbl[4]  = '{0, 12'h000, 1, 12'h013, 0, 1, 0, 10'd4, 0, 32'h0,        0, 32'h0,        0};
    tbl[5]  = '{0, 12'h000, 0, 12'h000, 0, 0, 0, 10'd0, 0, 32'h0,        1, 32'h0,        1};
    tbl[6]  = '{0, 12'h000, 0, 12'h000, 0, 0, 0, 10'd0, 0, 32'h0,        0, 32'h0,        0};
    tbl[7]  = '{1, 12'h020, 1, 12'h010, 0, 1, 1, 10'd4, 0, 32'h0,        0, 32'h0,        0};
    tbl[8]  = '{1, 12'h020, 1, 12'h010, 0, 1, 1, 10'd4, 0, 32'h0,        1, 32'hCAFEF00D, 0};
    tbl[9]  = '{1, 12'h020, 1, 12'h010, 0, 1, 1, 10'd4, 0, 32'h0,        1, 32'hCAFEF00D, 0};
    tbl[10] = '{1, 12'h020, 1, 12'h010, 0, 1, 1, 10'd4, 0, 32'h0,        1, 32'hCAFEF00D, 0};
    tbl[11] = '{1, 12'h020, 1, 12'h010, 1, 0, 1, 10'd8, 0, 32'h0,        1, 32'hCAFEF00D, 0};
    tbl[12] = '{1, 12'h020, 1, 12'h010, 0, 1, 1, 10'd4, 1, 32'h0BADC0DE, 0, 32'h0,        0};
    tbl[13] = '{0, 12'h000, 0, 12'h000, 0, 0, 0, 10'd0, 0, 32'h0,        1, 32'hCAFEF00D, 0};

    // Reset state, with requests asserted to show they are masked
    rst = 1'b1; i_req = 1'b1; i_addr = 12'h008; d_req = 1'b1; d_addr = 12'h010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt", 32'(i_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_stalls", 32'({i_stall, d_stall}), 0);
    chk("rst_rom_sel", 32'(rom_sel), 0);
    chk("rst_rvalids", 32'({i_rvalid, d_rvalid, d_err}), 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    chk("rst_stat", 32'(stat_conflicts), 0);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table, one row per cycle
    for (int r = 0; r < 14; r++) begin
      i_req = tbl[r].ir; i_addr = tbl[r].ia; d_req = tbl[r].dr; d_addr = tbl[r].da;
      @(negedge clk);
      chk($sformatf("t%0d_i_gnt", r), 32'(i_gnt), 32'(tbl[r].eig));
      chk($sformatf("t%0d_d_gnt", r), 32'(d_gnt), 32'(tbl[r].edg));
      chk($sformatf("t%0d_i_stall", r), 32'(i_stall), 32'(tbl[r].ir & ~tbl[r].eig));
      chk($sformatf("t%0d_d_stall", r), 32'(d_stall), 32'(tbl[r].dr & ~tbl[r].edg));
      chk($sformatf("t%0d_rom_sel", r), 32'(rom_sel), 32'(tbl[r].esel));
      chk($sformatf("t%0d_rom_addr", r), 32'(rom_addr), 32'(tbl[r].eaddr));
      chk($sformatf("t%0d_i_rvalid", r), 32'(i_rvalid), 32'(tbl[r].eirv));
      chk($sformatf("t%0d_d_rvalid", r), 32'(d_rvalid), 32'(tbl[r].edrv));
      chk($sformatf("t%0d_d_err", r), 32'(d_err), 32'(tbl[r].ederr));
      if (tbl[r].eirv) chk($sformatf("t%0d_i_rdata", r), i_rdata, tbl[r].eird);
      if (tbl[r].edrv) chk($sformatf("t%0d_d_rdata", r), d_rdata, tbl[r].edrd);
      if (r == 13) chk("stat_after_table", 32'(stat_conflicts), stats_en ? 32'd7 : 32'd0);
      @(posedge clk); #1;
    end

    // Reset lands while a fetch grant is outstanding
    i_req = 1'b1; i_addr = 12'h008; d_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_pre_gnt", 32'(i_gnt), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_gnts", 32'({i_gnt, d_gnt, i_stall, d_stall, rom_sel}), 0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 0);
    chk("mid_rst_regs", 32'({i_rvalid, d_rvalid, d_err}), 0);
    chk("mid_rst_stat", 32'(stat_conflicts), 0);
    @(posedge clk); #1;
    chk("mid_rst_no_rvalid", 32'(i_rvalid), 0);
    chk("mid_rst_rdata", i_rdata, 0);
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the model
    denials = 0; stat_m = 0;
    m_irv = 0; m_drv = 0; m_derr = 0; m_ird = '0; m_drd = '0;
    begin
      logic ig, dg, mis, prev_ig, prev_dg;
      prev_ig = 1'b0; prev_dg = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        // Mostly honour the hold-until-grant handshake, occasionally flush
        if (!(i_req && !prev_ig && ($urandom_range(0, 7) != 0))) begin
          i_req  = ($urandom_range(0, 2) != 0);
          i_addr = {10'($urandom_range(0, 1023)), 2'b00};
        end
        if (!(d_req && !prev_dg && ($urandom_range(0, 7) != 0))) begin
          d_req  = ($urandom_range(0, 2) == 0);
          d_addr = {10'($urandom_range(0, 1023)),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
        end
        mis = (d_addr[1:0] != 2'b00);
        if (i_req && d_req) begin
          ig = (denials >= MW);
          dg = !ig;
        end else begin
          ig = i_req;
          dg = d_req;
        end
        @(negedge clk);
        chk("rnd_i_gnt", 32'(i_gnt), 32'(ig));
        chk("rnd_d_gnt", 32'(d_gnt), 32'(dg));
        chk("rnd_stalls", 32'({i_stall, d_stall}), 32'({i_req & ~ig, d_req & ~dg}));
        chk("rnd_rom_sel", 32'(rom_sel), 32'(ig | (dg & ~mis)));
        chk("rnd_rom_addr", 32'(rom_addr),
            ig ? 32'(i_addr[11:2]) : (dg ? 32'(d_addr[11:2]) : 32'd0));
        chk("rnd_i_rvalid", 32'(i_rvalid), 32'(m_irv));
        chk("rnd_i_rdata", i_rdata, m_ird);
        chk("rnd_d_rvalid", 32'(d_rvalid), 32'(m_drv));
        chk("rnd_d_rdata", d_rdata, m_drd);
        chk("rnd_d_err", 32'(d_err), 32'(m_derr));
        chk("rnd_stat", 32'(stat_conflicts), stats_en ? 32'(stat_m) : 32'd0);
        // Advance the model to the state after this edge
        m_irv = ig;
        if (ig) m_ird = rom_mem[i_addr[11:2]];
        m_drv  = dg;
        m_derr = dg & mis;
        if (dg) m_drd = mis ? 32'h0 : rom_mem[d_addr[11:2]];
        if (i_req && !ig) denials = (denials < MW) ? denials + 1 : MW;
        else denials = 0;
        if (i_req && d_req && stat_m < 65535) stat_m++;
        prev_ig = ig; prev_dg = dg;
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
